// File: rtl/pll_seq_pkg.sv
// Shared types and default timing for the PLL reset sequencer.
// Optional heartbeat output is enabled with the PLL_SEQ_HEARTBEAT_EN macro.
package pll_seq_pkg;

    localparam int STATE_W    = 3;
    localparam int LOSS_CNT_W = 8;

    typedef enum logic [STATE_W-1:0] {
        WAIT_LOCK = 3'd0,
        STABILIZE = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        PLL_RST   = 3'd4
    } state_t;

    // Defaults assume the 36 MHz PLL output clock.
    localparam int DEF_STABLE_CYCLES  = 36000;
    localparam int DEF_LOCK_TIMEOUT   = 360000;
    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_NUM_DOMAINS    = 3;
    localparam int DEF_STAGGER        = 8;
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_HEARTBEAT_DIV  = 18000000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous bit.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL lock qualification and staggered per-domain reset release.
// Define PLL_SEQ_HEARTBEAT_EN to add the RUN-state heartbeat output.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int NUM_DOMAINS    = DEF_NUM_DOMAINS,
    parameter int STAGGER        = DEF_STAGGER,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES
`ifdef PLL_SEQ_HEARTBEAT_EN
    , parameter int HEARTBEAT_DIV = DEF_HEARTBEAT_DIV
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pll_lock,
    output logic                   pll_reset,
    output logic [NUM_DOMAINS-1:0] rst_dom,
    output logic                   ready,
    output logic [LOSS_CNT_W-1:0]  lock_loss_cnt,
    output logic [STATE_W-1:0]     state
`ifdef PLL_SEQ_HEARTBEAT_EN
    , output logic                 heartbeat
`endif
);

    localparam int TMR_MAX = max3(STABLE_CYCLES, LOCK_TIMEOUT, PLL_RST_CYCLES);
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;
    // rc runs one past the last release offset to time the move into RUN.
    localparam int RC_MAX  = (NUM_DOMAINS - 1) * STAGGER + 1;
    localparam int RC_W    = $clog2(RC_MAX) + 1;

    logic             lock_s;
    logic             lock_lost;
    state_t           state_q;
    logic [TMR_W-1:0] timer;
    logic [RC_W-1:0]  rc;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk(clk),
        .rst(rst),
        .d  (pll_lock),
        .q  (lock_s)
    );

    assign lock_lost = !lock_s && (state_q == RELEASE || state_q == RUN);
    assign state     = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= WAIT_LOCK;
            pll_reset     <= 1'b0;
            rst_dom       <= '1;
            ready         <= 1'b0;
            lock_loss_cnt <= '0;
            timer         <= '0;
            rc            <= '0;
        end else if (lock_lost) begin
            state_q <= WAIT_LOCK;
            rst_dom <= '1;
            ready   <= 1'b0;
            timer   <= '0;
            rc      <= '0;
            if (lock_loss_cnt != '1) begin
                lock_loss_cnt <= lock_loss_cnt + 1'b1;
            end
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_q <= STABILIZE;
                        timer   <= '0;
                    end else if (timer == TMR_W'(LOCK_TIMEOUT - 1)) begin
                        state_q   <= PLL_RST;
                        timer     <= '0;
                        pll_reset <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                PLL_RST: begin
                    if (timer == TMR_W'(PLL_RST_CYCLES - 1)) begin
                        state_q   <= WAIT_LOCK;
                        timer     <= '0;
                        pll_reset <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STABILIZE: begin
                    if (!lock_s) begin
                        state_q <= WAIT_LOCK;
                        timer   <= '0;
                    end else if (timer == TMR_W'(STABLE_CYCLES - 1)) begin
                        state_q <= RELEASE;
                        timer   <= '0;
                        rc      <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RELEASE: begin
                    for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
                        if (rc == RC_W'(i * STAGGER)) begin
                            rst_dom[i] <= 1'b0;
                        end
                    end
                    if (rc == RC_W'(RC_MAX)) begin
                        state_q <= RUN;
                        ready   <= 1'b1;
                        rc      <= '0;
                    end else begin
                        rc <= rc + 1'b1;
                    end
                end
                RUN: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= WAIT_LOCK;
                end
            endcase
        end
    end

`ifdef PLL_SEQ_HEARTBEAT_EN
    localparam int HB_W = $clog2(HEARTBEAT_DIV) + 1;

    logic [HB_W-1:0] hb_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hb_cnt    <= '0;
            heartbeat <= 1'b0;
        end else if (state_q == RUN) begin
            if (hb_cnt == HB_W'(HEARTBEAT_DIV - 1)) begin
                hb_cnt    <= '0;
                heartbeat <= ~heartbeat;
            end else begin
                hb_cnt <= hb_cnt + 1'b1;
            end
        end else begin
            hb_cnt    <= '0;
            heartbeat <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer with reduced timing parameters.
module tb_pll_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       pll_reset;
    logic [2:0] rst_dom;
    logic       ready;
    logic [7:0] lock_loss_cnt;
    logic [2:0] state;
`ifdef PLL_SEQ_HEARTBEAT_EN
    logic       heartbeat;
`endif

    pll_reset_sequencer #(
        .STABLE_CYCLES (20),
        .LOCK_TIMEOUT  (50),
        .PLL_RST_CYCLES(4),
        .NUM_DOMAINS   (3),
        .STAGGER       (2),
        .SYNC_STAGES   (2)
`ifdef PLL_SEQ_HEARTBEAT_EN
        , .HEARTBEAT_DIV(5)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pll_lock     (pll_lock),
        .pll_reset    (pll_reset),
        .rst_dom      (rst_dom),
        .ready        (ready),
        .lock_loss_cnt(lock_loss_cnt),
        .state        (state)
`ifdef PLL_SEQ_HEARTBEAT_EN
        , .heartbeat  (heartbeat)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        int unsigned due;
        logic [2:0]  st;
        logic [2:0]  dom;
        logic        rdy;
        logic        prst;
        logic [7:0]  cnt;
    } exp_t;

    typedef struct {
        int unsigned d;
        logic        lock;
        logic [2:0]  st;
        logic [2:0]  dom;
        logic        rdy;
        logic        prst;
        logic [7:0]  cnt;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic compare_one(input exp_t e);
        tests++;
        if (state !== e.st || rst_dom !== e.dom || ready !== e.rdy ||
            pll_reset !== e.prst || lock_loss_cnt !== e.cnt) begin
            fails++;
            $display("FAIL %s: got st=%0d dom=%b rdy=%b prst=%b cnt=%0d, want st=%0d dom=%b rdy=%b prst=%b cnt=%0d",
                     e.name, state, rst_dom, ready, pll_reset, lock_loss_cnt,
                     e.st, e.dom, e.rdy, e.prst, e.cnt);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %b, want %b", name, got, want);
        end
    endtask

    always @(negedge clk) begin : sampler
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            compare_one(e);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string name, input logic [2:0] st, input logic [2:0] dom,
                              input logic rdy, input logic prst, input logic [7:0] cnt);
        exp_t e;
        e.name = name; e.due = cyc; e.st = st; e.dom = dom;
        e.rdy = rdy; e.prst = prst; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (sb.size() > 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
            sb.delete();
        end
    endtask

    function automatic void add(input int unsigned d, input logic l, input logic [2:0] st,
                                input logic [2:0] dom, input logic rdy, input logic prst,
                                input logic [7:0] cnt);
        vec_t v;
        v.d = d; v.lock = l; v.st = st; v.dom = dom;
        v.rdy = rdy; v.prst = prst; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    // Releases rst at the base cycle, then drives lock and queues the expectation per record.
    task automatic run_vectors(input string tag);
        int unsigned base;
        @(posedge clk);
        #1;
        base = cyc;
        rst = 1'b0;
        foreach (vecs[k]) begin
            while (cyc < base + vecs[k].d) step();
            pll_lock = vecs[k].lock;
            expect_now($sformatf("%s[%0d]", tag, vecs[k].d), vecs[k].st, vecs[k].dom,
                       vecs[k].rdy, vecs[k].prst, vecs[k].cnt);
        end
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned o;
        o = 5;

        // Reset state while rst is held
        step(); step();
        expect_now("reset", 3'd0, 3'b111, 1'b0, 1'b0, 8'd0);
        drain();

        // Clean start, loss in RUN, full resequence
        vecs.delete();
        add(0,      1'b0, 3'd0, 3'b111, 1'b0, 1'b0, 8'd0);
        add(o + 0,  1'b1, 3'd0, 3'b111, 1'b0, 1'b0, 8'd0);
        add(o + 2,  1'b1, 3'd0, 3'b111, 1'b0, 1'b0, 8'd0);
        add(o + 3,  1'b1, 3'd1, 3'b111, 1'b0, 1'b0, 8'd0);
        add(o + 22, 1'b1, 3'd1, 3'b111, 1'b0, 1'b0, 8'd0);
        add(o + 23, 1'b1, 3'd2, 3'b111, 1'b0, 1'b0, 8'd0);
        add(o + 24, 1'b1, 3'd2, 3'b110, 1'b0, 1'b0, 8'd0);
        add(o + 25, 1'b1, 3'd2, 3'b110, 1'b0, 1'b0, 8'd0);
        add(o + 26, 1'b1, 3'd2, 3'b100, 1'b0, 1'b0, 8'd0);
        add(o + 27, 1'b1, 3'd2, 3'b100, 1'b0, 1'b0, 8'd0);
        add(o + 28, 1'b1, 3'd2, 3'b000, 1'b0, 1'b0, 8'd0);
        add(o + 29, 1'b1, 3'd3, 3'b000, 1'b1, 1'b0, 8'd0);
        add(o + 40, 1'b0, 3'd3, 3'b000, 1'b1, 1'b0, 8'd0);
        add(o + 42, 1'b0, 3'd3, 3'b000, 1'b1, 1'b0, 8'd0);
        add(o + 43, 1'b0, 3'd0, 3'b111, 1'b0, 1'b0, 8'd1);
        add(o + 45, 1'b1, 3'd0, 3'b111, 1'b0, 1'b0, 8'd1);
        add(o + 48, 1'b1, 3'd1, 3'b111, 1'b0, 1'b0, 8'd1);
        add(o + 68, 1'b1, 3'd2, 3'b111, 1'b0, 1'b0, 8'd1);
        add(o + 69, 1'b1, 3'd2, 3'b110, 1'b0, 1'b0, 8'd1);
        add(o + 73, 1'b1, 3'd2, 3'b000, 1'b0, 1'b0, 8'd1);
        add(o + 74, 1'b1, 3'd3, 3'b000, 1'b1, 1'b0, 8'd1);
        run_vectors("clean");

        // No lock: timeout pulses with a 54-cycle period
        rst = 1'b1; pll_lock = 1'b0; step();
        vecs.delete();
        add(0,   1'b0, 3'd0, 3'b111, 1'b0, 1'b0, 8'd0);
        add(49,  1'b0, 3'd0, 3'b111, 1'b0, 1'b0, 8'd0);
        add(50,  1'b0, 3'd4, 3'b111, 1'b0, 1'b1, 8'd0);
        add(53,  1'b0, 3'd4, 3'b111, 1'b0, 1'b1, 8'd0);
        add(54,  1'b0, 3'd0, 3'b111, 1'b0, 1'b0, 8'd0);
        add(103, 1'b0, 3'd0, 3'b111, 1'b0, 1'b0, 8'd0);
        add(104, 1'b0, 3'd4, 3'b111, 1'b0, 1'b1, 8'd0);
        add(107, 1'b0, 3'd4, 3'b111, 1'b0, 1'b1, 8'd0);
        add(108, 1'b0, 3'd0, 3'b111, 1'b0, 1'b0, 8'd0);
        run_vectors("nolock");

        // One-cycle glitch in STABILIZE restarts the window without counting a loss
        rst = 1'b1; pll_lock = 1'b0; step();
        vecs.delete();
        add(0,      1'b0, 3'd0, 3'b111, 1'b0, 1'b0, 8'd0);
        add(o + 0,  1'b1, 3'd0, 3'b111, 1'b0, 1'b0, 8'd0);
        add(o + 12, 1'b0, 3'd1, 3'b111, 1'b0, 1'b0, 8'd0);
        add(o + 13, 1'b1, 3'd1, 3'b111, 1'b0, 1'b0, 8'd0);
        add(o + 14, 1'b1, 3'd1, 3'b111, 1'b0, 1'b0, 8'd0);
        add(o + 15, 1'b1, 3'd0, 3'b111, 1'b0, 1'b0, 8'd0);
        add(o + 16, 1'b1, 3'd1, 3'b111, 1'b0, 1'b0, 8'd0);
        add(o + 23, 1'b1, 3'd1, 3'b111, 1'b0, 1'b0, 8'd0);
        add(o + 35, 1'b1, 3'd1, 3'b111, 1'b0, 1'b0, 8'd0);
        add(o + 36, 1'b1, 3'd2, 3'b111, 1'b0, 1'b0, 8'd0);
        add(o + 42, 1'b1, 3'd3, 3'b000, 1'b1, 1'b0, 8'd0);
        run_vectors("glitch");

`ifdef PLL_SEQ_HEARTBEAT_EN
        begin : hb_test
            logic        prev;
            int unsigned t1, t2, n, bad;
            prev = heartbeat; n = 0;
            while (heartbeat === prev && n < 20) begin step(); n++; end
            t1 = cyc; prev = heartbeat; n = 0;
            while (heartbeat === prev && n < 20) begin step(); n++; end
            t2 = cyc;
            tests++;
            if (t2 - t1 != 5) begin
                fails++;
                $display("FAIL hb_period: got %0d cycles, want 5", t2 - t1);
            end
            pll_lock = 1'b0;
            repeat (4) step();
            check_bit("hb_after_loss", heartbeat, 1'b0);
            pll_lock = 1'b1;
            bad = 0;
            repeat (20) begin step(); if (heartbeat !== 1'b0) bad++; end
            check_bit("hb_idle_outside_run", (bad == 0), 1'b1);
            repeat (20) step();
        end
`endif

        // Saturating loss counter; each loss is taken from RELEASE or RUN
        for (int k = 0; k < 260; k++) begin
            pll_lock = 1'b0;
            repeat (4) step();
            if (k == 0 || k == 253 || k == 254 || k == 259) begin
                expect_now($sformatf("sat[%0d]", k), 3'd0, 3'b111, 1'b0, 1'b0,
                           (k >= 254) ? 8'd255 : 8'(k + 1));
            end
            pll_lock = 1'b1;
            repeat (26) step();
        end
        expect_now("pre_async_rst", 3'd2, 3'b100, 1'b0, 1'b0, 8'd255);
        drain();

        // Asynchronous reset between edges, mid-RELEASE
        rst = 1'b1;
        #1;
        begin : async_chk
            exp_t e;
            e.name = "async_rst"; e.due = cyc; e.st = 3'd0; e.dom = 3'b111;
            e.rdy = 1'b0; e.prst = 1'b0; e.cnt = 8'd0;
            compare_one(e);
        end
        step();
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
